uart_rx_frame_ctrl: RTL and testbench

Frame-level controller that sequences the byte stream from the UART receiver into validated command frames. It sits between the UART receiver and the register/command decoder.
- Consumes the receiver's one-cycle data-valid pulse and byte.
- Hunts for a sync byte, parses the address, length and payload fields, then checks an XOR checksum.
- Buffers the payload and releases it downstream over a valid/ready stream only when the checksum passes.

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_buf.sv | 38 +++
 rtl/uart_rx_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame controller: state encoding,
// default sync marker and buffer pointer sizing.
package uart_frame_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_ADDR = 3'd1;
    localparam logic [STATE_W-1:0] ST_LEN  = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA = 3'd3;
    localparam logic [STATE_W-1:0] ST_CHK  = 3'd4;
    localparam logic [STATE_W-1:0] ST_EMIT = 3'd5;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Pointer width for a MAX_LEN-deep buffer; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, registered
// read. The read register returns 0 whenever the read port is disabled.
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port, zeroed when not streaming.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_en_i ? mem_q[rd_addr_i] : 8'h00;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART frame controller: hunts for SYNC, parses ADDR/LEN/payload/CHK,
// buffers the payload and streams it out only on a checksum match.
// Optional build macro UART_FRAME_STATS_EN adds good/error frame counters.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 480000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Frm_Valid,
    input  logic       i_Frm_Ready,
    output logic [7:0] o_Frm_Addr,
    output logic [7:0] o_Frm_Data,
    output logic       o_Frm_Last,
    output logic       o_Chk_Err,
    output logic       o_Len_Err,
    output logic       o_Timeout,
    output logic       o_Overrun,
    output logic       o_Busy
`ifdef UART_FRAME_STATS_EN
    ,
    input  logic        i_Stats_Clr,
    output logic [15:0] o_Good_Cnt,
    output logic [15:0] o_Err_Cnt
`endif
);

    localparam int unsigned   PW        = ptr_width(MAX_LEN);
    localparam int unsigned   TW        = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [8:0]    MAX_LEN_9 = 9'(MAX_LEN);

    logic [STATE_W-1:0] state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          chk_err_q, chk_err_d;
    logic          len_err_q, len_err_d;
    logic          tmo_q, tmo_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;

    logic          parsing_c;
    logic          tmo_hit_c;
    logic          xfer_c;
    logic          good_c;
    logic          wr_en_c;
    logic          rd_en_c;
    logic [PW-1:0] rd_addr_c;
    logic [8:0]    len_m1_c;

    assign parsing_c = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                       (state_q == ST_DATA) || (state_q == ST_CHK);
    assign tmo_hit_c = parsing_c && !i_Rx_DV && (cnt_q == TMO_LAST);
    assign xfer_c    = valid_q && i_Frm_Ready;
    assign len_m1_c  = {1'b0, len_q} - 9'd1;

    // State register.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a DV on the expiry cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_d = ST_ADDR;
            ST_ADDR: begin
                if (i_Rx_DV)        state_d = ST_LEN;
                else if (tmo_hit_c) state_d = ST_IDLE;
            end
            ST_LEN: begin
                if (i_Rx_DV) begin
                    if ({1'b0, i_Rx_Byte} > MAX_LEN_9) state_d = ST_IDLE;
                    else if (i_Rx_Byte == 8'h00)       state_d = ST_CHK;
                    else                               state_d = ST_DATA;
                end else if (tmo_hit_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (i_Rx_DV) begin
                    if (9'(wr_ptr_q) == len_m1_c) state_d = ST_CHK;
                end else if (tmo_hit_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (i_Rx_DV) begin
                    if ((i_Rx_Byte != chk_q) || (len_q == 8'h00)) state_d = ST_IDLE;
                    else                                          state_d = ST_EMIT;
                end else if (tmo_hit_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: if (xfer_c && last_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; the read address prefetches the next byte on a transfer.
    always_comb begin
        addr_d    = addr_q;
        len_d     = len_q;
        chk_d     = chk_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        chk_err_d = 1'b0;
        len_err_d = 1'b0;
        ovr_d     = 1'b0;
        good_c    = 1'b0;
        wr_en_c   = 1'b0;
        tmo_d     = tmo_hit_c;
        cnt_d     = (parsing_c && !i_Rx_DV && !tmo_hit_c) ? cnt_q + TW'(1) : '0;

        case (state_q)
            ST_ADDR: begin
                if (i_Rx_DV) begin
                    addr_d = i_Rx_Byte;
                    chk_d  = i_Rx_Byte;
                end
            end
            ST_LEN: begin
                if (i_Rx_DV) begin
                    chk_d = chk_q ^ i_Rx_Byte;
                    if ({1'b0, i_Rx_Byte} > MAX_LEN_9) begin
                        len_err_d = 1'b1;
                    end else begin
                        len_d    = i_Rx_Byte;
                        wr_ptr_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (i_Rx_DV) begin
                    wr_en_c  = 1'b1;
                    chk_d    = chk_q ^ i_Rx_Byte;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
            end
            ST_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte != chk_q) begin
                        chk_err_d = 1'b1;
                    end else begin
                        good_c   = 1'b1;
                        rd_ptr_d = '0;
                    end
                end
            end
            ST_EMIT: begin
                if (i_Rx_DV) ovr_d = 1'b1;
                if (xfer_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            end
            default: ;
        endcase

        if (state_q != ST_EMIT) rd_addr_c = '0;
        else if (xfer_c)        rd_addr_c = rd_ptr_q + PW'(1);
        else                    rd_addr_c = rd_ptr_q;

        rd_en_c = (state_d == ST_EMIT);
        valid_d = (state_d == ST_EMIT);
        last_d  = (state_d == ST_EMIT) && (9'(rd_addr_c) == len_m1_c);
        busy_d  = (state_d != ST_IDLE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            addr_q    <= 8'h00;
            len_q     <= 8'h00;
            chk_q     <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            chk_err_q <= 1'b0;
            len_err_q <= 1'b0;
            tmo_q     <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            chk_err_q <= chk_err_d;
            len_err_q <= len_err_d;
            tmo_q     <= tmo_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (PW)
    ) u_buf (
        .clk_i     (i_Clock),
        .rst_ni    (i_Rst_n),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (i_Rx_Byte),
        .rd_en_i   (rd_en_c),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (o_Frm_Data)
    );

    assign o_Frm_Valid = valid_q;
    assign o_Frm_Addr  = addr_q;
    assign o_Frm_Last  = last_q;
    assign o_Chk_Err   = chk_err_q;
    assign o_Len_Err   = len_err_q;
    assign o_Timeout   = tmo_q;
    assign o_Overrun   = ovr_q;
    assign o_Busy      = busy_q;

`ifdef UART_FRAME_STATS_EN
    logic [15:0] good_cnt_q;
    logic [15:0] err_cnt_q;
    logic        err_any_c;

    assign err_any_c = chk_err_d || len_err_d || tmo_d || ovr_d;

    // Saturating frame statistics; clear wins over increment.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            good_cnt_q <= 16'h0000;
            err_cnt_q  <= 16'h0000;
        end else if (i_Stats_Clr) begin
            good_cnt_q <= 16'h0000;
            err_cnt_q  <= 16'h0000;
        end else begin
            if (good_c && (good_cnt_q != 16'hFFFF))    good_cnt_q <= good_cnt_q + 16'd1;
            if (err_any_c && (err_cnt_q != 16'hFFFF))  err_cnt_q  <= err_cnt_q + 16'd1;
        end
    end

    assign o_Good_Cnt = good_cnt_q;
    assign o_Err_Cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a stream scoreboard.
module tb_uart_rx_frame_ctrl;

    localparam int unsigned MAXL = 16;
    localparam int unsigned TMO  = 20;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ready = 1'b1;
    logic       valid, last, chk_err, len_err, tmo, ovr, busy;
    logic [7:0] addr, data;
`ifdef UART_FRAME_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] good_cnt, err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

    logic [16:0] sb_q[$];
    logic [7:0]  pl [16];

    uart_rx_frame_ctrl #(
        .SYNC_BYTE    (SYNC),
        .MAX_LEN      (MAXL),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_DV     (rx_dv),
        .i_Rx_Byte   (rx_byte),
        .o_Frm_Valid (valid),
        .i_Frm_Ready (ready),
        .o_Frm_Addr  (addr),
        .o_Frm_Data  (data),
        .o_Frm_Last  (last),
        .o_Chk_Err   (chk_err),
        .o_Len_Err   (len_err),
        .o_Timeout   (tmo),
        .o_Overrun   (ovr),
        .o_Busy      (busy)
`ifdef UART_FRAME_STATS_EN
        ,
        .i_Stats_Clr (stats_clr),
        .o_Good_Cnt  (good_cnt),
        .o_Err_Cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: pops expected {last,addr,data} on each transfer,
    // checks hold-stability during stalls and counts error pulse cycles.
    logic        prev_stall = 1'b0;
    logic [16:0] prev_beat = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_beat", 32'({last, addr, data}), 32'(prev_beat));
            end
            if (valid && ready) begin
                if (sb_q.size() == 0) check("unexpected_beat", 32'({last, addr, data}), 32'h1FFFF);
                else check("stream", 32'({last, addr, data}), 32'(sb_q.pop_front()));
            end
            prev_stall = valid && !ready;
            prev_beat  = {last, addr, data};
            if (chk_err) n_chk++;
            if (len_err) n_len++;
            if (tmo)     n_tmo++;
            if (ovr)     n_ovr++;
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input int n, input logic corrupt);
        logic [7:0] c;
        c = a ^ 8'(n);
        send_byte(SYNC);
        send_byte(a);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            c = c ^ pl[i];
            if (!corrupt) sb_q.push_back({(i == n - 1), a, pl[i]});
            send_byte(pl[i]);
        end
        send_byte(corrupt ? 8'h00 : c);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'({busy, valid}), 32'd0);
    endtask

    initial begin
        int tmo_seen;
        // reset state
        #2;
        check("rst_outs", 32'({valid, last, chk_err, len_err, tmo, ovr, busy}), 32'd0);
        check("rst_bus", 32'({addr, data}), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // good frame: 10 03 11 22 33, CHK = 10^03^11^22^33 = 13
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(8'h10, 3, 1'b0);
        check("lat_valid", 32'({valid, busy}), 32'h3);
        drain("good3");
        check("good3_errs", 32'(n_chk + n_len + n_tmo + n_ovr), 32'd0);

        // same frame, CHK=00
        send_frame(8'h10, 3, 1'b1);
        check("bad_chk_valid", 32'(valid), 32'd0);
        @(posedge clk); #1;
        check("bad_chk_busy", 32'(busy), 32'd0);
        check("bad_chk_pulse", 32'(n_chk), 32'd1);

        // LEN beyond MAX_LEN, then a good single-byte frame
        send_byte(SYNC); send_byte(8'h01); send_byte(8'h11);
        @(posedge clk); #1;
        check("len_err_pulse", 32'(n_len), 32'd1);
        check("len_err_busy", 32'(busy), 32'd0);
        pl[0] = 8'h7E;
        send_frame(8'h02, 1, 1'b0);
        drain("after_len");

        // LEN == MAX_LEN accepted
        for (int i = 0; i < 16; i++) pl[i] = 8'(i * 17 + 3);
        send_frame(8'h33, 16, 1'b0);
        drain("maxlen");

        // zero-length frame: no stream, no error
        send_frame(8'h55, 0, 1'b0);
        check("len0_valid", 32'({valid, busy}), 32'd0);

        // sync byte value inside the frame is data
        pl[0] = SYNC; pl[1] = 8'h01;
        send_frame(SYNC, 2, 1'b0);
        drain("sync_in_frame");

        // timeout exactly TMO cycles after last DV
        send_byte(SYNC); send_byte(8'h20);
        tmo_seen = -1;
        for (int k = 1; k <= 2 * TMO && tmo_seen < 0; k++) begin
            @(posedge clk); #1;
            if (tmo) tmo_seen = k;
        end
        check("tmo_latency", 32'(tmo_seen), 32'(TMO));
        check("tmo_busy", 32'(busy), 32'd0);

        // DV on the expiry cycle prevents the timeout
        send_byte(SYNC); send_byte(8'h21);
        repeat (TMO - 1) @(posedge clk);
        #1;
        send_byte(8'h01);
        check("tmo_dv_wins", 32'({tmo, busy}), 32'h1);
        send_byte(8'h5A);
        sb_q.push_back({1'b1, 8'h21, 8'h5A});
        send_byte(8'h21 ^ 8'h01 ^ 8'h5A);
        drain("tmo_dv");
        check("tmo_count", 32'(n_tmo), 32'd1);

        // stalled stream with an overrun DV
        for (int i = 0; i < 4; i++) pl[i] = 8'(8'hC1 + i);
        send_frame(8'h44, 4, 1'b0);
        for (int c = 0; c < 60 && sb_q.size() != 0; c++) begin
            ready = (c % 4 == 0) || (c % 4 == 3);
            rx_dv = (c == 2);
            rx_byte = SYNC;
            @(posedge clk); #1;
            rx_dv = 1'b0;
        end
        ready = 1'b1;
        drain("stall");
        check("ovr_count", 32'(n_ovr), 32'd1);

        // reset mid-DATA
        send_byte(SYNC); send_byte(8'h30); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02);
        #2 rst_n = 1'b0;
        #1 check("rst_data", 32'({busy, valid, addr}), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        pl[0] = 8'h9C; pl[1] = 8'h3D;
        send_frame(8'h31, 2, 1'b0);
        drain("post_rst_data");

        // reset mid-EMIT
        ready = 1'b0;
        pl[0] = 8'hE0; pl[1] = 8'hE1; pl[2] = 8'hE2;
        send_frame(8'h40, 3, 1'b0);
        check("emit_before_rst", 32'(valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_emit", 32'({valid, last, busy, addr, data}), 32'd0);
        sb_q.delete();
        @(posedge clk); #1; rst_n = 1'b1; ready = 1'b1;
        pl[0] = 8'h12;
        send_frame(8'h41, 1, 1'b0);
        drain("post_rst_emit");
        check("final_errs", 32'({8'(n_chk), 8'(n_len), 8'(n_tmo), 8'(n_ovr)}), 32'h01010101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
